// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer in front of the machine-mode CSR file.
// Prioritises synchronous exceptions from execute, hands one trap at a time
// to the CSR file, then stalls/flushes/redirects the pipeline. Also sequences
// the mret return and goes to a sticky fatal halt if the CSR file never acks.
module trap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] instr_pc,
  input  logic [DATA_WIDTH-1:0] instr_word,
  input  logic                  exc_instr_misaligned,
  input  logic [DATA_WIDTH-1:0] exc_target,
  input  logic                  exc_illegal,
  input  logic                  exc_ecall,
  input  logic                  exc_ebreak,
  input  logic                  exc_load_misaligned,
  input  logic                  exc_store_misaligned,
  input  logic [DATA_WIDTH-1:0] exc_mem_addr,
  input  logic                  mret,
  input  logic [DATA_WIDTH-1:0] mepc,
  output logic                  trap,
  output logic [3:0]            trap_cause,
  output logic [DATA_WIDTH-1:0] trap_value,
  output logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  trap_handled,
  input  logic [DATA_WIDTH-1:0] trap_target_pc,
  output logic                  stall,
  output logic                  flush,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fatal,
  output logic [CNT_WIDTH-1:0]  trap_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_REDIR = 3'd3,
    ST_RET   = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  localparam logic [7:0]           TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                state_r;
  state_t                state_s;
  logic [7:0]            tmo_r;
  logic [7:0]            tmo_s;
  logic [7:0]            tmo_inc_s;

  logic                  exc_any_s;
  logic [3:0]            exc_cause_s;
  logic [DATA_WIDTH-1:0] exc_tval_s;

  logic                  trap_s;
  logic                  stall_s;
  logic                  flush_s;
  logic                  redirect_s;
  logic                  fatal_s;
  logic [3:0]            cause_s;
  logic [DATA_WIDTH-1:0] value_s;
  logic [DATA_WIDTH-1:0] pc_s;
  logic [DATA_WIDTH-1:0] redirect_pc_s;
  logic [CNT_WIDTH-1:0]  count_s;

  // Priority-encode the exception flags into cause code and mtval.
  always_comb begin
    exc_any_s   = instr_valid & (exc_instr_misaligned | exc_illegal | exc_ecall |
                                 exc_ebreak | exc_load_misaligned | exc_store_misaligned);
    exc_cause_s = 4'd0;
    exc_tval_s  = DATA_ZERO;
    if (exc_instr_misaligned) begin
      exc_cause_s = 4'd0;
      exc_tval_s  = exc_target;
    end else if (exc_illegal) begin
      exc_cause_s = 4'd2;
      exc_tval_s  = instr_word;
    end else if (exc_ecall) begin
      exc_cause_s = 4'd11;
      exc_tval_s  = DATA_ZERO;
    end else if (exc_ebreak) begin
      exc_cause_s = 4'd3;
      exc_tval_s  = DATA_ZERO;
    end else if (exc_load_misaligned) begin
      exc_cause_s = 4'd4;
      exc_tval_s  = exc_mem_addr;
    end else if (exc_store_misaligned) begin
      exc_cause_s = 4'd6;
      exc_tval_s  = exc_mem_addr;
    end else begin
      exc_cause_s = 4'd0;
      exc_tval_s  = DATA_ZERO;
    end
  end

  // Next-state logic, datapath latches and next-cycle output decode.
  always_comb begin
    state_s       = state_r;
    tmo_s         = tmo_r;
    tmo_inc_s     = tmo_r + 8'd1;
    cause_s       = trap_cause;
    value_s       = trap_value;
    pc_s          = trap_pc;
    redirect_pc_s = redirect_pc;
    count_s       = trap_count;
    trap_s        = 1'b0;
    stall_s       = 1'b0;
    flush_s       = 1'b0;
    redirect_s    = 1'b0;
    fatal_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // An exception always wins over a simultaneous mret.
        if (exc_any_s) begin
          cause_s = exc_cause_s;
          value_s = exc_tval_s;
          pc_s    = instr_pc;
          state_s = ST_REQ;
        end else if (instr_valid && mret) begin
          redirect_pc_s = mepc;
          state_s       = ST_RET;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        tmo_s   = 8'd0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack in the last allowed cycle still beats the timeout.
        tmo_s = tmo_inc_s;
        if (trap_handled) begin
          redirect_pc_s = trap_target_pc;
          if (trap_count != CNT_MAX) begin
            count_s = trap_count + CNT_ONE;
          end else begin
            count_s = trap_count;
          end
          state_s = ST_REDIR;
        end else if (tmo_inc_s >= TMO_LIMIT) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_REDIR: state_s = ST_IDLE;
      ST_RET:   state_s = ST_IDLE;
      ST_HALT:  state_s = ST_HALT;
      default:  state_s = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_s)
      ST_IDLE: begin
        stall_s = 1'b0;
      end
      ST_REQ: begin
        trap_s  = 1'b1;
        stall_s = 1'b1;
        flush_s = 1'b1;
      end
      ST_WAIT: begin
        stall_s = 1'b1;
      end
      ST_REDIR: begin
        redirect_s = 1'b1;
        stall_s    = 1'b1;
      end
      ST_RET: begin
        redirect_s = 1'b1;
        flush_s    = 1'b1;
        stall_s    = 1'b1;
      end
      ST_HALT: begin
        stall_s = 1'b1;
        fatal_s = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // State, timeout counter, latched trap data and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      tmo_r       <= 8'd0;
      trap        <= 1'b0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      fatal       <= 1'b0;
      trap_cause  <= 4'd0;
      trap_value  <= DATA_ZERO;
      trap_pc     <= DATA_ZERO;
      redirect_pc <= DATA_ZERO;
      trap_count  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      tmo_r       <= tmo_s;
      trap        <= trap_s;
      stall       <= stall_s;
      flush       <= flush_s;
      redirect    <= redirect_s;
      fatal       <= fatal_s;
      trap_cause  <= cause_s;
      trap_value  <= value_s;
      trap_pc     <= pc_s;
      redirect_pc <= redirect_pc_s;
      trap_count  <= count_s;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected trap/redirect
// events, an independent negedge monitor pops and compares them.
module tb_trap_ctrl;
  localparam int DW  = 32;
  localparam int TMO = 15;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic [DW-1:0] instr_pc, instr_word, exc_target, exc_mem_addr, mepc, trap_target_pc;
  logic          exc_instr_misaligned, exc_illegal, exc_ecall, exc_ebreak;
  logic          exc_load_misaligned, exc_store_misaligned, mret, trap_handled;
  logic          trap, stall, flush, redirect, fatal;
  logic [3:0]    trap_cause;
  logic [DW-1:0] trap_value, trap_pc, redirect_pc;
  logic [CW-1:0] trap_count;

  trap_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .instr_word(instr_word), .exc_instr_misaligned(exc_instr_misaligned),
    .exc_target(exc_target), .exc_illegal(exc_illegal), .exc_ecall(exc_ecall),
    .exc_ebreak(exc_ebreak), .exc_load_misaligned(exc_load_misaligned),
    .exc_store_misaligned(exc_store_misaligned), .exc_mem_addr(exc_mem_addr),
    .mret(mret), .mepc(mepc), .trap(trap), .trap_cause(trap_cause),
    .trap_value(trap_value), .trap_pc(trap_pc), .trap_handled(trap_handled),
    .trap_target_pc(trap_target_pc), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .fatal(fatal),
    .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  // kind 0 = trap request (cause, a=tval, b=pc); kind 1 = redirect (a=pc, b=flush, c=count)
  typedef struct {
    int          kind;
    logic [3:0]  cause;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   model_count = 0;
  int   cause_tab[6] = '{0, 2, 11, 3, 4, 6};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every trap or redirect pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (trap) begin
        if (exp_q.size() == 0) begin
          check("unexpected_trap", 64'(trap), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("trap_order", 64'(0), 64'(mon_e.kind));
          check("trap_cause", 64'(trap_cause), 64'(mon_e.cause));
          check("trap_value", 64'(trap_value), 64'(mon_e.a));
          check("trap_pc", 64'(trap_pc), 64'(mon_e.b));
          check("trap_stall_flush", 64'({stall, flush}), 64'(2'b11));
        end
      end
      if (redirect) begin
        if (exp_q.size() == 0) begin
          check("unexpected_redirect", 64'(redirect), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("redirect_order", 64'(1), 64'(mon_e.kind));
          check("redirect_pc", 64'(redirect_pc), 64'(mon_e.a));
          check("redirect_flush", 64'(flush), 64'(mon_e.b));
          check("trap_count", 64'(trap_count), 64'(mon_e.c));
          check("redirect_stall", 64'(stall), 64'(1));
        end
      end
    end
  end

  task automatic clear_inputs();
    instr_valid = 1'b0; mret = 1'b0;
    {exc_instr_misaligned, exc_illegal, exc_ecall, exc_ebreak,
     exc_load_misaligned, exc_store_misaligned} = 6'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({trap, stall, flush, redirect, fatal}), 64'(0));
    check({tag, "_cause"}, 64'(trap_cause), 64'(0));
    check({tag, "_value"}, 64'(trap_value), 64'(0));
    check({tag, "_tpc"}, 64'(trap_pc), 64'(0));
    check({tag, "_rpc"}, 64'(redirect_pc), 64'(0));
    check({tag, "_count"}, 64'(trap_count), 64'(0));
  endtask

  // Call at posedge+1; reset sampled at the next edge.
  task automatic do_reset(input string tag);
    clear_inputs();
    trap_handled = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_count = 0;
    check_all_zero(tag);
  endtask

  // fl: {store, load, ebreak, ecall, illegal, instr_misaligned}. Call at posedge+1, DUT idle.
  task automatic issue(input logic [5:0] fl, input logic v, input logic m,
                       input logic [31:0] pc, input logic [31:0] word,
                       input logic [31:0] tgt, input logic [31:0] addr,
                       input logic [31:0] mepc_v, input bit do_ack,
                       input int ack_dly, input logic [31:0] handler);
    int   idx;
    exp_t e;
    idx = -1;
    for (int i = 0; i < 6; i++) if (fl[i] && idx < 0) idx = i;
    instr_valid = v; instr_pc = pc; instr_word = word; exc_target = tgt;
    exc_mem_addr = addr; mret = m; mepc = mepc_v;
    {exc_store_misaligned, exc_load_misaligned, exc_ebreak,
     exc_ecall, exc_illegal, exc_instr_misaligned} = fl;
    if (v && idx >= 0) begin
      e.kind = 0; e.cause = 4'(cause_tab[idx]); e.b = pc; e.c = 32'd0;
      case (idx)
        0:       e.a = tgt;
        1:       e.a = word;
        2, 3:    e.a = 32'd0;
        default: e.a = addr;
      endcase
      exp_q.push_back(e);
      if (do_ack) begin
        model_count = (model_count + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : model_count + 1;
        e.kind = 1; e.cause = 4'd0; e.a = handler; e.b = 32'd0; e.c = 32'(model_count);
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check("trap_latency", 64'(trap), 64'(1));
      if (do_ack) begin
        for (int k = 0; k < ack_dly; k++) begin
          @(posedge clk); #1;
          instr_valid = 1'b1; mret = 1'($urandom_range(0, 1));
          {exc_store_misaligned, exc_load_misaligned, exc_ebreak,
           exc_ecall, exc_illegal, exc_instr_misaligned} = 6'($urandom_range(1, 63));
        end
        @(posedge clk); #1;
        clear_inputs();
        trap_handled = 1'b1; trap_target_pc = handler;
        @(posedge clk); #1;
        trap_handled = 1'b0;
        @(negedge clk);
        check("redirect_latency", 64'(redirect), 64'(1));
        @(posedge clk); #1;
      end
    end else if (v && m) begin
      e.kind = 1; e.cause = 4'd0; e.a = mepc_v; e.b = 32'd1; e.c = 32'(model_count);
      exp_q.push_back(e);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check("mret_redirect", 64'({redirect, trap}), 64'(2'b10));
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check("no_event", 64'({trap, redirect, stall}), 64'(0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trap_handled = 1'b0; trap_target_pc = '0;
    instr_pc = '0; instr_word = '0; exc_target = '0; exc_mem_addr = '0; mepc = '0;
    clear_inputs();
    @(posedge clk); #1;
    do_reset("reset");

    // Illegal at 0x100, acked next cycle with handler 0x200.
    issue(6'b000010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 32'h200);
    check("count_after_first", 64'(trap_count), 64'(1));
    // Load-misaligned + ecall -> ecall wins.
    issue(6'b010100, 1'b1, 1'b0, 32'h40, 32'h73, 32'h0, 32'h1003, 32'h0, 1'b1, 1, 32'h300);
    // Instr-misaligned + illegal -> misaligned wins.
    issue(6'b000011, 1'b1, 1'b0, 32'h44, 32'hFFFF_FFFF, 32'h42, 32'h0, 32'h0, 1'b1, 2, 32'h400);
    // Plain mret, then mret + ebreak.
    issue(6'b000000, 1'b1, 1'b1, 32'h48, 32'h0, 32'h0, 32'h0, 32'h104, 1'b1, 0, 32'h0);
    issue(6'b001000, 1'b1, 1'b1, 32'h4C, 32'h0, 32'h0, 32'h0, 32'h104, 1'b1, 0, 32'h500);
    // Flags without instr_valid.
    issue(6'b111111, 1'b0, 1'b1, 32'h50, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 32'h0);

    // Randomised traffic with noise on trap_handled between events.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] fl;
      fl = ($urandom_range(0, 2) == 0) ? 6'b0 : 6'($urandom_range(0, 63));
      issue(fl, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            {$urandom} & 32'hFFFF_FFFC, $urandom, $urandom, $urandom, $urandom,
            1'b1, $urandom_range(0, 5), {$urandom} & 32'hFFFF_FFFC);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        trap_handled = 1'($urandom_range(0, 1)); trap_target_pc = $urandom;
        @(posedge clk); #1;
      end
      trap_handled = 1'b0;
    end

    // Timeout: no ack -> fatal after exactly TMO WAIT cycles.
    issue(6'b010000, 1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 32'h601, 32'h0, 1'b0, 0, 32'h0);
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      check("fatal_early", 64'({fatal, stall}), 64'(2'b01));
    end
    @(negedge clk);
    check("fatal_set", 64'({fatal, stall, trap, redirect, flush}), 64'(5'b11000));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      instr_valid = 1'b1; exc_illegal = 1'b1; mret = 1'b1;
      trap_handled = 1'b1; trap_target_pc = 32'h700;
      @(negedge clk);
      check("halt_sticky", 64'({fatal, stall, trap, redirect, flush}), 64'(5'b11000));
    end
    @(posedge clk); #1;
    do_reset("halt_reset");

    // Reset in the middle of WAIT, then a late ack must be ignored.
    issue(6'b000100, 1'b1, 1'b0, 32'h800, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    @(posedge clk); #1;
    do_reset("wait_reset");
    trap_handled = 1'b1; trap_target_pc = 32'h900;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_ack_ignored", 64'({redirect, stall}), 64'(0));
    end
    @(posedge clk); #1;
    trap_handled = 1'b0;

    // Saturation: 2^CW + 2 acknowledged traps.
    for (int n = 0; n < (1 << CW) + 2; n++) begin
      issue(6'b001000, 1'b1, 1'b0, 32'(n * 4), 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 32'hA00);
    end
    check("count_saturated", 64'(trap_count), 64'(4'hF));

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer that sits directly upstream of the machine-mode CSR file.
- Collects synchronous exception flags and mret from the execute stage, prioritises them and encodes cause and tval.
- Issues a single-cycle trap request to the CSR file, waits for its trap_handled/trap_target_pc response, then stalls, flushes and redirects the pipeline.
- Also handles the mret return path using mepc, and detects a CSR file that never acknowledges a trap.

Parameters:
DATA_WIDTH, 32, width of PC, tval and instruction words
TIMEOUT, 15, max cycles to wait for trap_handled before fatal (1..255)
CNT_WIDTH, 16, width of saturating trap counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
instr_valid  input  1  execute-stage instruction valid this cycle
instr_pc  input  DATA_WIDTH  PC of executing instruction
instr_word  input  DATA_WIDTH  raw instruction bits
exc_instr_misaligned  input  1  branch/jump target misaligned
exc_target  input  DATA_WIDTH  offending branch/jump target
exc_illegal  input  1  illegal instruction
exc_ecall  input  1  ECALL
exc_ebreak  input  1  EBREAK
exc_load_misaligned  input  1  load address misaligned
exc_store_misaligned  input  1  store address misaligned
exc_mem_addr  input  DATA_WIDTH  effective load/store address
mret  input  1  MRET executing
mepc  input  DATA_WIDTH  current mepc value from CSR file
trap  output  1  trap request to CSR file
trap_cause  output  4  exception code
trap_value  output  DATA_WIDTH  mtval value
trap_pc  output  DATA_WIDTH  faulting PC (mepc value)
trap_handled  input  1  CSR file acknowledge
trap_target_pc  input  DATA_WIDTH  handler address from CSR file
stall  output  1  freeze fetch/decode/execute
flush  output  1  kill in-flight younger instructions
redirect  output  1  load redirect_pc into PC
redirect_pc  output  DATA_WIDTH  new PC
fatal  output  1  sticky: CSR file failed to acknowledge
trap_count  output  CNT_WIDTH  saturating count of taken traps

Behaviour:
- Reset (rst high at a clock edge): state IDLE. trap, stall, flush, redirect and fatal are 0. trap_cause, trap_value, trap_pc, redirect_pc and trap_count are 0. The timeout counter is 0. rst asserted in any state, including mid-handshake, returns to IDLE on that edge.
- Exception detect: exc_any is the OR of the six exc_* flags, qualified by instr_valid.
- Exception priority and encoding (cause, tval), highest first:
  - instr_misaligned: 0, exc_target
  - illegal: 2, instr_word
  - ecall: 11, 0
  - ebreak: 3, 0
  - load_misaligned: 4, exc_mem_addr
  - store_misaligned: 6, exc_mem_addr
- State IDLE:
  - stall=0.
  - If exc_any: latch cause, tval and instr_pc into trap_cause, trap_value and trap_pc. Go to REQ.
  - Else if instr_valid and mret: latch mepc into redirect_pc. Go to RET.
  - An exception beats mret in the same cycle.
  - Flags with instr_valid=0 are ignored.
- State REQ:
  - trap=1 for exactly this one cycle; stall=1; flush=1.
  - Clear the timeout counter. Go to WAIT.
- State WAIT:
  - trap=0, stall=1. The timeout counter increments each cycle.
  - On trap_handled=1: latch trap_target_pc into redirect_pc, increment trap_count (saturates at all-ones, no wrap), go to REDIR.
  - Else, when the counter reaches TIMEOUT: set fatal, go to HALT.
  - New exception flags or mret arriving in WAIT are ignored; the pipeline is stalled.
- State REDIR:
  - redirect=1 and stall=1 for one cycle, with redirect_pc as the handler address. Go to IDLE.
- State RET:
  - redirect=1, flush=1 and stall=1 for one cycle, with redirect_pc=mepc. Go to IDLE.
  - No CSR file request is made for mret.
- State HALT:
  - stall=1 permanently; trap, redirect and flush are 0; fatal=1.
  - Only rst leaves HALT.
- Latency:
  - Exception sampled at edge N: trap high in cycle N+1.
  - With the CSR file acking at the next edge (trap_handled high in cycle N+2), redirect is high in cycle N+3.
  - Three stall cycles minimum per trap.
- trap_handled seen outside WAIT is ignored.
- trap_cause, trap_value and trap_pc hold their values until the next trap is latched.

Test Plan:
- Illegal at pc=0x100, instr_word=0x0000_0000, CSR file acks one cycle after trap with target 0x200 -> trap pulses 1 cycle, cause=2, value=0x0, trap_pc=0x100. redirect=1 with redirect_pc=0x200 two cycles after trap. trap_count=1.
- Load-misaligned and ecall together at pc=0x40, mem_addr=0x1003 -> cause=11, value=0. Then instr_misaligned and illegal together with target 0x42 -> cause=0, value=0x42.
- mret with mepc=0x104, no exception -> one cycle with redirect=1, flush=1, redirect_pc=0x104; trap never asserted. mret plus ebreak in the same cycle -> trap with cause=3.
- trap_handled held low after trap with TIMEOUT=15 -> fatal=1 after 15 WAIT cycles; stall stuck at 1; later exceptions and trap_handled ignored. rst clears fatal and stall.
- rst asserted while in WAIT -> next cycle all outputs are 0 and state is IDLE. A late trap_handled is ignored, with no redirect.
- 2^CNT_WIDTH+2 acknowledged traps (CNT_WIDTH=4 build) -> trap_count saturates at 0xF. Exception flags with instr_valid=0 produce no trap.
